// File: rtl/ps2_receptor.sv
// PS/2 keyboard frame receiver: synchronises and deglitches the line pair, checks
// framing/odd parity and strips E0/F0 prefixes, flagging key releases in liberado.
module ps2_receptor #(
  parameter int FILTRO         = 4,
  parameter int TIMEOUT_CICLOS = 5000
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] dato,
  output logic       listo,
  output logic       liberado,
  output logic       error
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] DATOS   = 2'd1;
  localparam logic [1:0] PARIDAD = 2'd2;
  localparam logic [1:0] STOP    = 2'd3;

  localparam logic [3:0]  FILTRO_MAX = 4'(FILTRO - 1);
  localparam logic [15:0] TMO_MAX    = 16'(TIMEOUT_CICLOS - 1);

  logic [1:0]  clk_sync;
  logic [1:0]  dat_sync;
  logic        clk_s;
  logic        dato_bit;
  logic        clk_filt;
  logic        clk_filt_next;
  logic [3:0]  cnt_filtro;
  logic        caida;
  logic [1:0]  estado;
  logic [2:0]  cnt_bits;
  logic [7:0]  byte_rx;
  logic        paridad_ok;
  logic        pend_lib;
  logic [15:0] cnt_tmo;
  logic        timeout;

  assign clk_s    = clk_sync[1];
  assign dato_bit = dat_sync[1];

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
    end
  end

  // The falling edge is taken from the filter's next value so the FSM acts on the
  // same edge the filtered clock drops, giving a FILTRO+2 cycle commit latency.
  always_comb begin
    clk_filt_next = clk_filt;
    if (clk_s != clk_filt && cnt_filtro == FILTRO_MAX)
      clk_filt_next = clk_s;
  end

  assign caida   = clk_filt & ~clk_filt_next;
  assign timeout = (estado != IDLE) && (cnt_tmo == TMO_MAX);

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      clk_filt   <= 1'b1;
      cnt_filtro <= 4'd0;
    end else begin
      clk_filt <= clk_filt_next;
      if (clk_s == clk_filt || cnt_filtro == FILTRO_MAX)
        cnt_filtro <= 4'd0;
      else
        cnt_filtro <= cnt_filtro + 4'd1;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset)
      cnt_tmo <= 16'd0;
    else if (estado == IDLE || caida)
      cnt_tmo <= 16'd0;
    else
      cnt_tmo <= cnt_tmo + 16'd1;
  end

  // Timeout wins over a simultaneous falling edge; every error drops a pending F0.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      estado     <= IDLE;
      cnt_bits   <= 3'd0;
      byte_rx    <= 8'h00;
      paridad_ok <= 1'b0;
      pend_lib   <= 1'b0;
      dato       <= 8'h00;
      liberado   <= 1'b0;
      listo      <= 1'b0;
      error      <= 1'b0;
    end else begin
      listo <= 1'b0;
      error <= 1'b0;
      if (timeout) begin
        estado   <= IDLE;
        error    <= 1'b1;
        pend_lib <= 1'b0;
      end else if (caida) begin
        case (estado)
          IDLE: begin
            if (!dato_bit) begin
              estado   <= DATOS;
              cnt_bits <= 3'd0;
            end
          end
          DATOS: begin
            byte_rx  <= {dato_bit, byte_rx[7:1]};
            cnt_bits <= cnt_bits + 3'd1;
            if (cnt_bits == 3'd7)
              estado <= PARIDAD;
          end
          PARIDAD: begin
            paridad_ok <= ^{byte_rx, dato_bit};
            estado     <= STOP;
          end
          STOP: begin
            estado <= IDLE;
            if (dato_bit && paridad_ok) begin
              if (byte_rx == 8'hF0) begin
                pend_lib <= 1'b1;
              end else if (byte_rx != 8'hE0) begin
                dato     <= byte_rx;
                liberado <= pend_lib;
                listo    <= 1'b1;
                pend_lib <= 1'b0;
              end
            end else begin
              error    <= 1'b1;
              pend_lib <= 1'b0;
            end
          end
          default: estado <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_receptor.sv
// Self-checking bench for ps2_receptor: table of frames feeding a scoreboard,
// plus hand-written latency, timeout, glitch and mid-frame reset sequences.
module tb_ps2_receptor;

  localparam int FILTRO = 4;
  localparam int TMO    = 200;
  localparam int HALF   = 20;
  localparam int LAT    = FILTRO + 2;

  logic       CLK = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] dato;
  logic       listo;
  logic       liberado;
  logic       error;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       is_err;
    logic [7:0] dato;
    logic       lib;
  } sb_t;

  typedef struct {
    logic [7:0] code;
    logic       par_flip;
    logic       stop_bit;
    logic       glitch;
    logic       measure;
    int         kind;
    logic [7:0] exp_dato;
    logic       exp_lib;
  } vec_t;

  sb_t  sb[$];
  sb_t  mon_e;
  vec_t vecs[$];

  ps2_receptor #(.FILTRO(FILTRO), .TIMEOUT_CICLOS(TMO)) dut (
    .CLK(CLK),
    .reset(reset),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .dato(dato),
    .listo(listo),
    .liberado(liberado),
    .error(error)
  );

  always #10 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mkVec(input logic [7:0] code, input logic pf, input logic sbit,
                                 input logic gl, input logic ms, input int kind,
                                 input logic [7:0] d, input logic l);
    vec_t v;
    v.code = code; v.par_flip = pf; v.stop_bit = sbit; v.glitch = gl;
    v.measure = ms; v.kind = kind; v.exp_dato = d; v.exp_lib = l;
    return v;
  endfunction

  // kind: 0 nothing expected, 1 listo, 2 error.
  task automatic sendBit(input logic b, input logic glitch, input logic measure, input int kind);
    ps2_data = b;
    repeat (HALF) @(negedge CLK);
    ps2_clk = 1'b0;
    if (measure) begin
      for (int i = 1; i <= LAT; i++) begin
        @(posedge CLK);
        #1;
        if (i >= LAT - 1)
          checkOutput("latency", 32'((kind == 2) ? error : listo), 32'(i == LAT));
      end
      repeat (HALF - LAT) @(negedge CLK);
    end else begin
      repeat (HALF) @(negedge CLK);
    end
    ps2_clk = 1'b1;
    if (glitch) begin
      repeat (6) @(negedge CLK);
      ps2_clk = 1'b0;
      repeat (2) @(negedge CLK);
      ps2_clk = 1'b1;
      repeat (HALF - 8) @(negedge CLK);
    end else begin
      repeat (HALF) @(negedge CLK);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    logic par;
    sb_t  e;
    par = ~(^v.code) ^ v.par_flip;
    if (v.kind != 0) begin
      e.is_err = (v.kind == 2);
      e.dato   = v.exp_dato;
      e.lib    = v.exp_lib;
      sb.push_back(e);
    end
    sendBit(1'b0, v.glitch, 1'b0, 0);
    for (int i = 0; i < 8; i++)
      sendBit(v.code[i], v.glitch, 1'b0, 0);
    sendBit(par, v.glitch, 1'b0, 0);
    sendBit(v.stop_bit, v.glitch, v.measure, v.kind);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge CLK);
  endtask

  always @(negedge CLK) begin
    if (listo || error) begin
      if (listo && error) begin
        checks++;
        errors++;
        $display("[TB] FAIL both_pulses: listo=%0b error=%0b, expected at most one", listo, error);
      end
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_pulse: listo=%0b error=%0b dato=0x%0h, expected none", listo, error, dato);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("pulse_kind", 32'(error), 32'(mon_e.is_err));
        checkOutput("dato", 32'(dato), 32'(mon_e.dato));
        checkOutput("liberado", 32'(liberado), 32'(mon_e.lib));
      end
    end
  end

  initial begin
    sb_t e;
    reset    = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;

    vecs.push_back(mkVec(8'h1C, 1'b0, 1'b1, 1'b0, 1'b1, 1, 8'h1C, 1'b0));
    vecs.push_back(mkVec(8'hF0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 8'h00, 1'b0));
    vecs.push_back(mkVec(8'h1C, 1'b0, 1'b1, 1'b0, 1'b0, 1, 8'h1C, 1'b1));
    vecs.push_back(mkVec(8'h29, 1'b0, 1'b1, 1'b0, 1'b0, 1, 8'h29, 1'b0));
    vecs.push_back(mkVec(8'hE0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 8'h00, 1'b0));
    vecs.push_back(mkVec(8'h1C, 1'b0, 1'b1, 1'b0, 1'b0, 1, 8'h1C, 1'b0));
    vecs.push_back(mkVec(8'hF0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 8'h00, 1'b0));
    vecs.push_back(mkVec(8'h1C, 1'b1, 1'b1, 1'b0, 1'b1, 2, 8'h1C, 1'b0));
    vecs.push_back(mkVec(8'h1C, 1'b0, 1'b0, 1'b0, 1'b0, 2, 8'h1C, 1'b0));
    vecs.push_back(mkVec(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 1, 8'h5A, 1'b0));
    vecs.push_back(mkVec(8'hF0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 8'h00, 1'b0));
    vecs.push_back(mkVec(8'hE0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 8'h00, 1'b0));
    vecs.push_back(mkVec(8'h29, 1'b0, 1'b1, 1'b0, 1'b0, 1, 8'h29, 1'b1));
    vecs.push_back(mkVec(8'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 1, 8'h1C, 1'b0));

    repeat (3) @(negedge CLK);
    checkOutput("reset_dato", 32'(dato), 32'h00);
    checkOutput("reset_listo", 32'(listo), 32'h0);
    checkOutput("reset_liberado", 32'(liberado), 32'h0);
    checkOutput("reset_error", 32'(error), 32'h0);
    reset = 1'b1;
    repeat (HALF) @(negedge CLK);

    for (int i = 0; i < vecs.size(); i++)
      applyStimulus(vecs[i]);

    // Partial frame after a pending F0: timeout must fire and drop the release flag.
    applyStimulus(mkVec(8'hF0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 8'h00, 1'b0));
    e.is_err = 1'b1; e.dato = 8'h1C; e.lib = 1'b0;
    sb.push_back(e);
    sendBit(1'b0, 1'b0, 1'b0, 0);
    sendBit(1'b1, 1'b0, 1'b0, 0);
    sendBit(1'b0, 1'b0, 1'b0, 0);
    ps2_data = 1'b0;
    repeat (HALF) @(negedge CLK);
    ps2_clk = 1'b0;
    for (int i = 1; i <= LAT + TMO; i++) begin
      @(posedge CLK);
      #1;
      if (i == HALF)
        ps2_clk = 1'b1;
      if (i >= LAT + TMO - 1)
        checkOutput("timeout_edge", 32'(error), 32'(i == LAT + TMO));
    end
    ps2_data = 1'b1;
    repeat (HALF) @(negedge CLK);
    applyStimulus(mkVec(8'h29, 1'b0, 1'b1, 1'b0, 1'b0, 1, 8'h29, 1'b0));

    // Mid-frame reset with a release pending and non-zero outputs held.
    applyStimulus(mkVec(8'hF0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 8'h00, 1'b0));
    applyStimulus(mkVec(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 1, 8'h5A, 1'b1));
    applyStimulus(mkVec(8'hF0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 8'h00, 1'b0));
    sendBit(1'b0, 1'b0, 1'b0, 0);
    sendBit(1'b1, 1'b0, 1'b0, 0);
    sendBit(1'b0, 1'b0, 1'b0, 0);
    sendBit(1'b1, 1'b0, 1'b0, 0);
    reset = 1'b0;
    repeat (2) @(negedge CLK);
    checkOutput("midreset_dato", 32'(dato), 32'h00);
    checkOutput("midreset_listo", 32'(listo), 32'h0);
    checkOutput("midreset_liberado", 32'(liberado), 32'h0);
    checkOutput("midreset_error", 32'(error), 32'h0);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (3) @(negedge CLK);
    reset = 1'b1;
    repeat (HALF) @(negedge CLK);
    applyStimulus(mkVec(8'h1C, 1'b0, 1'b1, 1'b0, 1'b1, 1, 8'h1C, 1'b0));

    repeat (50) @(negedge CLK);
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_receptor.md
# ps2_receptor

PS/2 keyboard frame receiver that turns the raw `ps2_clk`/`ps2_data` line pair into validated scan-code bytes. It sits directly upstream of the command-receive stage of the alarm system and drives that stage's 8-bit `dato` input. The block also strips the break (F0) and extended (E0) prefixes, flagging key releases instead of forwarding the prefix bytes.

## Interface
Parameters:
- `FILTRO`, default 4: consecutive equal samples required before the filtered `ps2_clk` changes level. Legal range is 2–15.
- `TIMEOUT_CICLOS`, default 5000: CLK cycles without a filtered falling edge that abort a partial frame. This is 100 µs at 50 MHz. Legal range is 16–65535.

Ports:
- `CLK`  in  1  system clock; the only clock in the block.
- `reset`  in  1  reset; asynchronous, active-low.
- `ps2_clk`  in  1  raw PS/2 clock from the keyboard; asynchronous; idles high.
- `ps2_data`  in  1  raw PS/2 data from the keyboard; asynchronous; idles high.
- `dato`  out  8  last accepted scan code; held until the next accepted code.
- `listo`  out  1  one-cycle pulse; `dato`/`liberado` updated this cycle.
- `liberado`  out  1  set when the code in `dato` was preceded by an F0 prefix (key release).
- `error`  out  1  one-cycle pulse on a framing error, parity error, or timeout.

## Operation
- Synchronisers: `ps2_clk` and `ps2_data` each pass through 2 flip-flops. Both synchroniser chains reset to 1.
- Glitch filter on the synchronised clock:
  - A counter increments while the synchronised clock differs from the filtered clock, and clears when they are equal.
  - When the count reaches `FILTRO`, the filtered clock takes the new level.
  - The filtered clock resets to 1.
- Edge detection: `caida` = (previous filtered clock) AND NOT (filtered clock). All FSM actions occur on CLK edges where `caida`=1, sampling the synchronised data bit.
- FSM states: IDLE, DATOS, PARIDAD, STOP.
  - IDLE: on `caida` with data=0, go to DATOS and clear the bit counter. With data=1, stay in IDLE; no error is raised.
  - DATOS: shift the data bit into the byte register LSB-first. After the 8th bit, go to PARIDAD.
  - PARIDAD: store the parity bit. The parity check passes when XOR of the 8 data bits and the parity bit equals 1 (odd parity). Go to STOP.
  - STOP: the frame is good when data=1 and parity passed; otherwise pulse `error`. Return to IDLE in both cases.
- Commit of a good frame:
  - Byte F0: set internal `pend_lib`. No `listo`.
  - Byte E0: discard. `pend_lib` is unchanged. No `listo`.
  - Any other byte: `dato` ← byte, `liberado` ← `pend_lib`, pulse `listo`, clear `pend_lib`.
- Timeout:
  - A 16-bit counter clears on every `caida` and while in IDLE.
  - In any state other than IDLE, when the counter reaches `TIMEOUT_CICLOS-1`, return to IDLE, pulse `error`, and clear `pend_lib`.
  - Timeout has priority over a `caida` in the same cycle.
- Any `error` also clears `pend_lib`.

## Timing
- Reset values: `dato`=0x00, `listo`=0, `liberado`=0, `error`=0, FSM=IDLE, `pend_lib`=0, all counters 0.
- Reset asserted mid-frame aborts the frame immediately. No `listo` or `error` pulse is produced.
- Latency: `listo` (or the STOP-state `error`) is high during the cycle after the (FILTRO+2)th CLK edge, counted from the first edge that sampled raw `ps2_clk` low at the stop bit.
  - With FILTRO=4, this is 6 edges.
  - Latency is constant and frame-independent.
- Data sampling point: `ps2_data` is effectively sampled about FILTRO+2 cycles after the raw clock falls. This is well inside the ≥30 µs PS/2 clock-low phase.
- Glitch rejection: low pulses on `ps2_clk` shorter than FILTRO cycles never produce `caida`.
- Output pulse widths: `listo` and `error` are exactly 1 cycle wide, and are never high in the same cycle.
- Throughput: back-to-back frames need no idle time beyond the stop bit. The FSM is in IDLE on the cycle after commit.
- Host-to-device (inhibit, RTS) is not supported. The block only listens.

## Test plan
- Frame 0x1C (start 0; data 0,0,1,1,1,0,0,0; parity 0; stop 1) at 12 kHz line clock, 50 MHz CLK → single `listo` pulse; `dato`=0x1C; `liberado`=0; `error` stays 0.
- Sequence F0 (parity 1), then 0x1C → no `listo` on F0; `listo` on 0x1C with `dato`=0x1C and `liberado`=1. A following 0x29 (parity 0) gives `liberado`=0.
- Sequence E0, then 0x1C → only one `listo`; `dato`=0x1C; `liberado`=0.
- 0x1C sent with parity bit 1, then 0x1C sent with stop bit 0 → one `error` pulse each; no `listo`; `dato` keeps its prior value.
- Start bit plus 3 data bits, then the line is held idle → `error` exactly `TIMEOUT_CICLOS` cycles after the last `caida`. A full 0x29 frame sent next is received correctly.
- 2-cycle low glitches on `ps2_clk` (FILTRO=4) inserted between bits of 0x1C → frame is still received as 0x1C. `reset` pulsed mid-frame → all outputs return to their reset values, and the next frame is received correctly.
